// File: rtl/sc_backg_pkg.sv
// sc_backg_pkg: shared state, shift-code and level encodings for the background-lane sequencer
package sc_backg_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, MERGE, RUN} seqState_t;
    localparam logic [1:0] SHIFT_HOLD  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] LEVEL0 = 2'd0;
    localparam logic [1:0] LEVEL1 = 2'd1;
    localparam logic [1:0] LEVEL2 = 2'd2;
    localparam logic [1:0] LEVEL3 = 2'd3;
endpackage

// File: rtl/sc_backg_tick_prescaler.sv
// sc_backg_tick_prescaler: free-running divider emitting a one-cycle tick at count == period-1
module sc_backg_tick_prescaler #(
    parameter int PERIOD_WIDTH = 26
) (
    input  logic                    SC_LastRegBACKGTYPE_CLOCK_50,
    input  logic                    SC_LastRegBACKGTYPE_RESET_InHigh,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    tick
);
    logic [PERIOD_WIDTH-1:0] count;
    logic                    atEnd;

    assign atEnd = count == period - PERIOD_WIDTH'(1);
    // clear has priority so a tick coinciding with a level change or game over is dropped
    assign tick  = enable && !clear && atEnd;

    always_ff @(posedge SC_LastRegBACKGTYPE_CLOCK_50 or posedge SC_LastRegBACKGTYPE_RESET_InHigh) begin
        if (SC_LastRegBACKGTYPE_RESET_InHigh) count <= '0;
        else if (clear)                       count <= '0;
        else if (enable)                      count <= atEnd ? '0 : count + PERIOD_WIDTH'(1);
    end
endmodule

// File: rtl/sc_backg_lane_sequencer.sv
// sc_backg_lane_sequencer: sequences start, level loads and paced scrolling of the last background lane register
module sc_backg_lane_sequencer
    import sc_backg_pkg::*;
#(
    parameter int         PERIOD_WIDTH = 26,
    parameter int         PERIOD_L0    = 25000000,
    parameter int         PERIOD_L1    = 18750000,
    parameter int         PERIOD_L2    = 12500000,
    parameter int         PERIOD_L3    = 6250000,
    parameter logic [3:0] LEVEL_DIR    = 4'b0101
) (
    input  logic       SC_LastRegBACKGTYPE_CLOCK_50,
    input  logic       SC_LastRegBACKGTYPE_RESET_InHigh,
    input  logic       start_InLow,
    input  logic       levelup_In,
    input  logic       gameover_In,
    input  logic       pause_In,
    output logic       clear_OutLow,
    output logic       load_OutLow,
    output logic       loadfinal_OutLow,
    output logic [1:0] shiftselection_OutBUS,
    output logic [1:0] transitioncounter_OutBUS,
    output logic       running_Out,
    output logic       levelwrap_Out
);
    seqState_t               state, nState;
    logic [1:0]              level, nLevel, dirCode;
    logic                    wrap, tick, prescClear, prescEnable;
    logic [PERIOD_WIDTH-1:0] period;

    assign period = level == LEVEL0 ? PERIOD_WIDTH'(PERIOD_L0) :
                    level == LEVEL1 ? PERIOD_WIDTH'(PERIOD_L1) :
                    level == LEVEL2 ? PERIOD_WIDTH'(PERIOD_L2) : PERIOD_WIDTH'(PERIOD_L3);
    assign dirCode     = LEVEL_DIR[level] ? SHIFT_LEFT : SHIFT_RIGHT;
    assign prescClear  = state != RUN || levelup_In || gameover_In;
    assign prescEnable = state == RUN && !pause_In;

    sc_backg_tick_prescaler #(.PERIOD_WIDTH(PERIOD_WIDTH)) prescaler (
        .SC_LastRegBACKGTYPE_CLOCK_50    (SC_LastRegBACKGTYPE_CLOCK_50),
        .SC_LastRegBACKGTYPE_RESET_InHigh(SC_LastRegBACKGTYPE_RESET_InHigh),
        .clear                           (prescClear),
        .enable                          (prescEnable),
        .period                          (period),
        .tick                            (tick)
    );

    always_comb begin
        nState = state;
        nLevel = level;
        wrap   = 1'b0;
        case (state)
            IDLE:    if (!start_InLow) begin nState = LOAD; nLevel = LEVEL0; end
            LOAD:    nState = MERGE;
            MERGE:   nState = RUN;
            RUN:     if (levelup_In) begin nState = LOAD; nLevel = level + 2'd1; wrap = level == LEVEL3; end
            default: nState = IDLE;
        endcase
        // game over outranks level-up in every active state
        if (gameover_In && state != IDLE) begin
            nState = IDLE;
            nLevel = LEVEL0;
            wrap   = 1'b0;
        end
    end

    // outputs are registered from the next state so every strobe is glitch-free
    always_ff @(posedge SC_LastRegBACKGTYPE_CLOCK_50 or posedge SC_LastRegBACKGTYPE_RESET_InHigh) begin
        if (SC_LastRegBACKGTYPE_RESET_InHigh) begin
            state                 <= IDLE;
            level                 <= LEVEL0;
            clear_OutLow          <= 1'b0;
            load_OutLow           <= 1'b1;
            loadfinal_OutLow      <= 1'b1;
            shiftselection_OutBUS <= SHIFT_HOLD;
            running_Out           <= 1'b0;
            levelwrap_Out         <= 1'b0;
        end else begin
            state                 <= nState;
            level                 <= nLevel;
            clear_OutLow          <= nState != IDLE;
            load_OutLow           <= nState != LOAD;
            loadfinal_OutLow      <= nState != MERGE;
            shiftselection_OutBUS <= tick ? dirCode : SHIFT_HOLD;
            running_Out           <= nState == RUN;
            levelwrap_Out         <= wrap;
        end
    end

    assign transitioncounter_OutBUS = level;
endmodule

// File: tb/tb_sc_backg_lane_sequencer.sv
// tb_sc_backg_lane_sequencer: directed plus randomized checks against a countdown-based game model
module tb_sc_backg_lane_sequencer;
    localparam int         P[4] = '{8, 6, 4, 2};
    localparam logic [3:0] DIR  = 4'b0101;

    logic       clk = 1'b0, rst = 1'b1;
    logic       startN = 1'b1, levelUp = 1'b0, gameOver = 1'b0, pause = 1'b0;
    logic       clearN, loadN, loadFinalN, running, levelWrap;
    logic [1:0] shiftSel, transCnt;

    int errors = 0, checks = 0;
    // model: phase 0 waiting, 1 loading, 2 merging, 3 scrolling; shiftsLeft counts unpaused edges to next shift
    int mPhase = 0, mLevel = 0, shiftsLeft = 0;
    logic [1:0] mShift = 2'b00;
    logic       mWrap = 1'b0;

    sc_backg_lane_sequencer #(
        .PERIOD_WIDTH(26), .PERIOD_L0(8), .PERIOD_L1(6), .PERIOD_L2(4), .PERIOD_L3(2), .LEVEL_DIR(4'b0101)
    ) dut (
        .SC_LastRegBACKGTYPE_CLOCK_50    (clk),
        .SC_LastRegBACKGTYPE_RESET_InHigh(rst),
        .start_InLow                     (startN),
        .levelup_In                      (levelUp),
        .gameover_In                     (gameOver),
        .pause_In                        (pause),
        .clear_OutLow                    (clearN),
        .load_OutLow                     (loadN),
        .loadfinal_OutLow                (loadFinalN),
        .shiftselection_OutBUS           (shiftSel),
        .transitioncounter_OutBUS        (transCnt),
        .running_Out                     (running),
        .levelwrap_Out                   (levelWrap)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic checkOutputs();
        checkValue("clear",     32'(clearN),     32'(mPhase != 0));
        checkValue("load",      32'(loadN),      32'(mPhase != 1));
        checkValue("loadfinal", 32'(loadFinalN), 32'(mPhase != 2));
        checkValue("running",   32'(running),    32'(mPhase == 3));
        checkValue("level",     32'(transCnt),   32'(mLevel));
        checkValue("shift",     32'(shiftSel),   32'(mShift));
        checkValue("wrap",      32'(levelWrap),  32'(mWrap));
    endtask

    task automatic modelReset();
        mPhase = 0; mLevel = 0; shiftsLeft = 0; mShift = 2'b00; mWrap = 1'b0;
    endtask

    task automatic modelEdge(input logic s, input logic l, input logic g, input logic p);
        mShift = 2'b00;
        mWrap  = 1'b0;
        if (mPhase == 0) begin
            if (!s) begin mPhase = 1; mLevel = 0; end
        end else if (g) begin
            mPhase = 0; mLevel = 0;
        end else if (mPhase == 3 && l) begin
            mWrap = mLevel == 3; mLevel = (mLevel + 1) % 4; mPhase = 1;
        end else if (mPhase == 1) begin
            mPhase = 2;
        end else if (mPhase == 2) begin
            mPhase = 3; shiftsLeft = P[mLevel];
        end else if (!p) begin
            shiftsLeft--;
            if (shiftsLeft == 0) begin
                mShift = DIR[mLevel] ? 2'b01 : 2'b10;
                shiftsLeft = P[mLevel];
            end
        end
    endtask

    task automatic step(input logic s, input logic l, input logic g, input logic p);
        @(negedge clk);
        startN = s; levelUp = l; gameOver = g; pause = p;
        @(posedge clk);
        modelEdge(s, l, g, p);
        #1 checkOutputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        modelReset();
        #12 checkOutputs();
        @(negedge clk) rst = 1'b0;
        idle(10);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(30);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            idle(19);
        end
        idle(3);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(12);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle(5);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(5);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(5);
        checkValue("level before reset", 32'(transCnt), 32'd2);
        @(posedge clk);
        #2 rst = 1'b1;
        modelReset();
        #1 checkOutputs();
        @(negedge clk) rst = 1'b0;
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(12);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
